// File: rtl/adc_spi_responder_pkg.sv
// Shared definitions for the ADC SPI responder: default geometry, FSM
// state encoding, pattern_mode encodings and checker pattern constants.
package adc_spi_responder_pkg;

  localparam int unsigned DATA_BITS_DEF  = 12;
  localparam int unsigned LEAD_ZEROS_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PM_FIXED    = 2'd0,
    PM_RAMP     = 2'd1,
    PM_CHECKER  = 2'd2,
    PM_RESERVED = 2'd3
  } pattern_t;

  localparam logic [11:0] CHECKER_A = 12'hAAA;
  localparam logic [11:0] CHECKER_B = 12'h555;

endpackage

// File: rtl/adc_spi_responder_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input, followed by a one-flop
// history stage producing single-cycle rise/fall pulses.
module sync_edge_det #(
  parameter logic IDLE_LEVEL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise,
  output logic fall
);

  logic       meta;
  logic       sync;
  logic       prev;
  logic [2:0] primed;

  // Synchronizer chain plus history; primed marks when prev holds a real sample
  always_ff @(posedge clk) begin
    if (rst) begin
      meta   <= IDLE_LEVEL;
      sync   <= IDLE_LEVEL;
      prev   <= IDLE_LEVEL;
      primed <= '0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      prev   <= sync;
      primed <= {primed[1:0], 1'b1};
    end
  end

  // Edges are suppressed until the chain is refilled after reset, so an input
  // already away from its idle level does not look like a fresh edge.
  assign rise = primed[2] &  sync & ~prev;
  assign fall = primed[2] & ~sync &  prev;

endmodule

// File: rtl/adc_spi_responder.sv
// SPI slave emulating a serial ADC: on CS fall it captures a test-pattern
// sample and shifts {lead zeros, sample} out MSB-first on SCLK falling edges.
module adc_spi_responder
  import adc_spi_responder_pkg::*;
#(
  parameter int unsigned DATA_BITS  = DATA_BITS_DEF,
  parameter int unsigned LEAD_ZEROS = LEAD_ZEROS_DEF
) (
  input  logic                 SYSCLK,
  input  logic                 SYSRESET,
  input  logic                 adc_cs_n,
  input  logic                 adc_sclk,
  output logic                 adc_dout,
  output logic                 adc_dout_oe,
  input  logic                 enable,
  input  logic [1:0]           pattern_mode,
  input  logic [DATA_BITS-1:0] fixed_value,
  output logic                 frame_done,
  output logic                 frame_abort,
  output logic [15:0]          frame_count
);

  localparam int unsigned FRAME_BITS = LEAD_ZEROS + DATA_BITS;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);
  localparam logic [DATA_BITS-1:0] CHK_A = DATA_BITS'(CHECKER_A);
  localparam logic [DATA_BITS-1:0] CHK_B = DATA_BITS'(CHECKER_B);

  logic cs_rise, cs_fall, sclk_fall, unused_sclk_rise;

  sync_edge_det #(.IDLE_LEVEL(1'b1)) u_cs_sync (
    .clk      (SYSCLK),
    .rst      (SYSRESET),
    .async_in (adc_cs_n),
    .rise     (cs_rise),
    .fall     (cs_fall)
  );

  sync_edge_det #(.IDLE_LEVEL(1'b1)) u_sclk_sync (
    .clk      (SYSCLK),
    .rst      (SYSRESET),
    .async_in (adc_sclk),
    .rise     (unused_sclk_rise),
    .fall     (sclk_fall)
  );

  state_t                 state, state_n;
  logic [FRAME_BITS-1:0]  shifter, shifter_n;
  logic [CNT_W-1:0]       bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0]   ramp, ramp_n, chk, chk_n, sample;
  pattern_t               mode_q, mode_n, mode_in;
  logic                   dout_n, oe_n, done_n, abort_n;
  logic [15:0]            count_n;

  assign mode_in = pattern_t'(pattern_mode);

  // Pattern source selection; reserved mode falls back to the fixed value
  always_comb begin
    case (mode_in)
      PM_RAMP:    sample = ramp;
      PM_CHECKER: sample = chk;
      default:    sample = fixed_value;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge SYSCLK) begin
    if (SYSRESET) begin
      state       <= ST_IDLE;
      shifter     <= '0;
      bit_cnt     <= '0;
      ramp        <= '0;
      chk         <= CHK_A;
      mode_q      <= PM_FIXED;
      adc_dout    <= 1'b0;
      adc_dout_oe <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_n;
      shifter     <= shifter_n;
      bit_cnt     <= bit_cnt_n;
      ramp        <= ramp_n;
      chk         <= chk_n;
      mode_q      <= mode_n;
      adc_dout    <= dout_n;
      adc_dout_oe <= oe_n;
      frame_done  <= done_n;
      frame_abort <= abort_n;
      frame_count <= count_n;
    end
  end

  // Next-state and output logic for the IDLE/SHIFT/HOLD frame sequencer
  always_comb begin
    state_n   = state;
    shifter_n = shifter;
    bit_cnt_n = bit_cnt;
    ramp_n    = ramp;
    chk_n     = chk;
    mode_n    = mode_q;
    dout_n    = adc_dout;
    oe_n      = adc_dout_oe;
    done_n    = 1'b0;
    abort_n   = 1'b0;
    count_n   = frame_count;
    case (state)
      ST_IDLE: begin
        if (cs_fall && enable) begin
          shifter_n = {{LEAD_ZEROS{1'b0}}, sample};
          dout_n    = shifter_n[FRAME_BITS-1];
          oe_n      = 1'b1;
          bit_cnt_n = '0;
          mode_n    = mode_in;
          state_n   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          abort_n = 1'b1;
          oe_n    = 1'b0;
          dout_n  = 1'b0;
          state_n = ST_IDLE;
        end else if (sclk_fall) begin
          shifter_n = shifter << 1;
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
            dout_n  = 1'b0;
            state_n = ST_HOLD;
          end else begin
            dout_n = shifter[FRAME_BITS-2];
          end
        end
      end
      ST_HOLD: begin
        if (cs_rise) begin
          done_n  = 1'b1;
          count_n = frame_count + 1'b1;
          oe_n    = 1'b0;
          dout_n  = 1'b0;
          state_n = ST_IDLE;
          // Each generator advances only when a frame it supplied completes
          if (mode_q == PM_RAMP)    ramp_n = ramp + 1'b1;
          if (mode_q == PM_CHECKER) chk_n  = (chk == CHK_A) ? CHK_B : CHK_A;
        end
      end
      default: begin
        oe_n    = 1'b0;
        dout_n  = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule
